// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry holding register.
//
// Frames are 1 start bit (0), 8 data bits LSB first and 1 stop bit (1).
// The line idles high. The rx pin is brought into the clk domain through a
// two-flop synchroniser, and every decision is made on the second flop (rs).
// Bits are sampled at mid-bit.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         UART line, asynchronous to clk
//   rx_data    received byte; stable while rx_valid is high
//   rx_valid   holding register full
//   rx_ready   consumer accepts rx_data when rx_valid & rx_ready
//   frame_err  one-cycle pulse when a stop bit is sampled as 0
//   overrun    sticky; a completed byte was dropped because the register was full
//   ovr_clr    synchronous clear of overrun (a same-cycle overrun event wins)
//
// Handshake: a transfer happens on every rising clk edge where rx_valid and
// rx_ready are both high. rx_valid then drops on the following cycle unless
// a new byte is delivered on that same edge. rx_data changes only when the
// register is loaded. The frame state machine never waits on rx_ready.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 217
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       ovr_clr
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        rs_q, rs_d;
   logic [15:0] clk_count_q, clk_count_d;
   logic [2:0]  bit_index_q, bit_index_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        overrun_q, overrun_d;
   logic        deliver;

   always_comb begin
      sync1_d     = rx;
      rs_d        = sync1_q;
      state_d     = state_q;
      clk_count_d = clk_count_q;
      bit_index_d = bit_index_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
      deliver     = 1'b0;

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (ovr_clr)                overrun_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            clk_count_d = '0;
            bit_index_d = '0;
            if (!rs_q) state_d = S_START;
         end
         S_START: begin
            if (clk_count_q == HALF) begin
               clk_count_d = '0;
               // A line that is high again at mid start bit was only a glitch.
               state_d     = rs_q ? S_IDLE : S_DATA;
            end else begin
               clk_count_d = clk_count_q + 16'd1;
            end
         end
         S_DATA: begin
            if (clk_count_q == LAST) begin
               clk_count_d          = '0;
               shift_d[bit_index_q] = rs_q;
               if (bit_index_q == 3'd7) begin
                  bit_index_d = '0;
                  state_d     = S_STOP;
               end else begin
                  bit_index_d = bit_index_q + 3'd1;
               end
            end else begin
               clk_count_d = clk_count_q + 16'd1;
            end
         end
         S_STOP: begin
            if (clk_count_q == LAST) begin
               clk_count_d = '0;
               // Return to IDLE at mid stop bit so back-to-back frames and
               // moderate baud mismatch are tolerated.
               if (rs_q) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               clk_count_d = clk_count_q + 16'd1;
            end
         end
         S_BREAK: begin
            // A held-low line reports a single frame error, not one per frame time.
            clk_count_d = '0;
            if (rs_q) state_d = S_IDLE;
         end
         default: begin
            clk_count_d = '0;
            bit_index_d = '0;
            state_d     = S_IDLE;
         end
      endcase

      // A byte is loaded if the register is empty or is being emptied on
      // this very edge; otherwise the old byte is kept and the new one lost.
      if (deliver) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         rs_q        <= 1'b1;
         clk_count_q <= '0;
         bit_index_q <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rs_q        <= rs_d;
         clk_count_q <= clk_count_d;
         bit_index_q <= bit_index_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// A bit-level line driver sends 8N1 frames; a frame-level model of the
// holding register predicts which bytes are handed over, what stays in the
// register and when overrun is set. A negedge monitor collects handshake
// transfers, frame_err pulses and rx_valid cycles.
module tb_uart_rx;

   localparam int CPB = 217;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard: bytes the model says the consumer will take, and bytes seen.
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int fe_cnt = 0;
   int valid_cnt = 0;

   // Frame-level model of the holding register.
   bit         m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   bit         m_ovr = 1'b0;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (frame_err) fe_cnt++;
         if (rx_valid) valid_cnt++;
      end
   end

   // Advance n negedges, then step 1 time unit so drives never race the monitor.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop);
      rx = 1'b0;
      tick(cpb);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(cpb);
      end
      rx = stop;
      tick(cpb);
      if (stop) begin
         if (rx_ready) exp_q.push_back(b);
         else if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = b;
         end else m_ovr = 1'b1;
      end
   endtask

   task automatic test_reset();
      tick(3);
      n_cmp += 4;
      if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
      if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
      rst_n = 1'b1;
      tick(10);
      n_cmp++;
      if (rx_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b expected 0", rx_valid); end
   endtask

   task automatic test_single();
      int lat;
      bit found;
      logic [7:0] d_seen;
      logic fe_seen, ovr_seen, v_after;
      int g0;
      g0 = got_q.size();
      rx_ready = 1'b1;
      lat = 0;
      found = 1'b0;
      d_seen = 8'h00; fe_seen = 1'b0; ovr_seen = 1'b0; v_after = 1'b1;
      fork
         send_frame(8'hA5, CPB, 1'b1);
         begin
            while (!found && lat < 3000) begin
               @(negedge clk);
               lat++;
               if (rx_valid) begin
                  found = 1'b1;
                  d_seen = rx_data; fe_seen = frame_err; ovr_seen = overrun;
                  @(negedge clk);
                  v_after = rx_valid;
               end
            end
         end
      join
      tick(CPB);
      n_cmp += 6;
      if (!found || lat < 2064 || lat > 2066) begin n_err++; $display("FAIL single_latency: got %0d expected 2065+-1", lat); end
      if (d_seen !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h expected a5", d_seen); end
      if (fe_seen !== 1'b0) begin n_err++; $display("FAIL single_ferr: got %b expected 0", fe_seen); end
      if (ovr_seen !== 1'b0) begin n_err++; $display("FAIL single_ovr: got %b expected 0", ovr_seen); end
      if (v_after !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %b expected 0", v_after); end
      if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d expected %0d", got_q.size() - g0, exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int g0, f0;
      logic [7:0] bytes[6];
      g0 = got_q.size();
      f0 = fe_cnt;
      bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
      for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 6; i++) send_frame(bytes[i], CPB, 1'b1);
      tick(CPB);
      n_cmp += 3;
      if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size() - g0, exp_q.size()); end
      if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL b2b_ferr: got %0d expected 0", fe_cnt - f0); end
      if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ovr: got %b expected 0", overrun); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (g0 + i >= got_q.size() || got_q[g0 + i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL b2b_data[%0d]: got %h expected %h", i, (g0 + i < got_q.size()) ? got_q[g0 + i] : 8'hxx, exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_glitch();
      int g0, f0, v0;
      g0 = got_q.size(); f0 = fe_cnt; v0 = valid_cnt;
      tick($urandom_range(5, 40));
      rx = 1'b0;
      tick(50);
      rx = 1'b1;
      tick(2 * CPB);
      n_cmp += 2;
      if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL glitch_valid: got %0d cycles expected 0", valid_cnt - v0); end
      if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt - f0); end
      send_frame(8'h3C, CPB, 1'b1);
      tick(CPB);
      n_cmp += 2;
      if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL glitch_count: got %0d expected 1", got_q.size() - g0); end
      else if (got_q[g0] !== exp_q[0]) begin n_err++; $display("FAIL glitch_data: got %h expected %h", got_q[g0], exp_q[0]); end
      if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_ferr2: got %0d expected 0", fe_cnt - f0); end
      exp_q.delete();
   endtask

   task automatic test_frame_err();
      int g0, f0, v0;
      g0 = got_q.size(); f0 = fe_cnt; v0 = valid_cnt;
      send_frame(8'h81, CPB, 1'b0);
      tick(10);
      n_cmp += 2;
      if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - f0); end
      if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL ferr_valid: got %0d cycles expected 0", valid_cnt - v0); end
      tick(30 * CPB);
      n_cmp += 2;
      if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL break_ferr: got %0d expected 1", fe_cnt - f0); end
      if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL break_valid: got %0d cycles expected 0", valid_cnt - v0); end
      rx = 1'b1;
      tick(2 * CPB);
      send_frame(8'h42, CPB, 1'b1);
      tick(CPB);
      n_cmp += 2;
      if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL ferr_next_count: got %0d expected 1", got_q.size() - g0); end
      else if (got_q[g0] !== exp_q[0]) begin n_err++; $display("FAIL ferr_next_data: got %h expected %h", got_q[g0], exp_q[0]); end
      if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_total: got %0d expected 1", fe_cnt - f0); end
      exp_q.delete();
   endtask

   task automatic test_overrun();
      int g0;
      int rates[2];
      rates[0] = 208; rates[1] = 226;
      rx_ready = 1'b0;
      send_frame(8'h11, CPB, 1'b1);
      send_frame(8'h22, CPB, 1'b1);
      tick(5);
      n_cmp += 3;
      if (rx_valid !== m_valid) begin n_err++; $display("FAIL ovr_valid: got %b expected %b", rx_valid, m_valid); end
      if (rx_data !== m_data) begin n_err++; $display("FAIL ovr_data: got %h expected %h", rx_data, m_data); end
      if (overrun !== m_ovr) begin n_err++; $display("FAIL ovr_flag: got %b expected %b", overrun, m_ovr); end
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      m_valid = 1'b0;
      tick(1);
      n_cmp += 2;
      if (rx_valid !== m_valid) begin n_err++; $display("FAIL ovr_accept: got %b expected %b", rx_valid, m_valid); end
      if (overrun !== m_ovr) begin n_err++; $display("FAIL ovr_sticky: got %b expected %b", overrun, m_ovr); end
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      m_ovr = 1'b0;
      tick(1);
      n_cmp++;
      if (overrun !== m_ovr) begin n_err++; $display("FAIL ovr_clear: got %b expected %b", overrun, m_ovr); end
      rx_ready = 1'b1;
      g0 = got_q.size();
      for (int r = 0; r < 2; r++) begin
         tick($urandom_range(1, 60));
         send_frame(8'($urandom_range(0, 255)), rates[r], 1'b1);
         send_frame(8'($urandom_range(0, 255)), rates[r], 1'b1);
      end
      tick(CPB);
      n_cmp++;
      if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL baud_count: got %0d expected %0d", got_q.size() - g0, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (g0 + i >= got_q.size() || got_q[g0 + i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL baud_data[%0d]: got %h expected %h", i, (g0 + i < got_q.size()) ? got_q[g0 + i] : 8'hxx, exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      int g0, f0, v0;
      b = 8'hC3;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = b[4];
      tick(CPB / 2);
      rst_n = 1'b0;
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
      #1;
      n_cmp += 4;
      if (rx_valid !== m_valid) begin n_err++; $display("FAIL rst_mid_valid: got %b expected %b", rx_valid, m_valid); end
      if (rx_data !== m_data) begin n_err++; $display("FAIL rst_mid_data: got %h expected %h", rx_data, m_data); end
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_ferr: got %b expected 0", frame_err); end
      if (overrun !== m_ovr) begin n_err++; $display("FAIL rst_mid_ovr: got %b expected %b", overrun, m_ovr); end
      rx = 1'b1;
      tick(20);
      rst_n = 1'b1;
      g0 = got_q.size(); f0 = fe_cnt; v0 = valid_cnt;
      tick(3 * CPB);
      n_cmp += 2;
      if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL rst_mid_noerr: got %0d expected 0", fe_cnt - f0); end
      if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL rst_mid_novalid: got %0d expected 0", valid_cnt - v0); end
      send_frame(8'h7E, CPB, 1'b1);
      tick(CPB);
      n_cmp++;
      if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL rst_next_count: got %0d expected 1", got_q.size() - g0); end
      else if (got_q[g0] !== exp_q[0]) begin n_err++; $display("FAIL rst_next_data: got %h expected %h", got_q[g0], exp_q[0]); end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Idle line is high.
- Pairs with the design's uart_tx and uses the same CLKS_PER_BIT timing (25 MHz / 115200 baud).
- Synchronises the asynchronous rx pin, samples each bit at mid-bit, and presents bytes through a one-entry holding register with a valid/ready handshake.
- Reports framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 217, clocks per bit. Legal range is 4..65535. HALF = (CLKS_PER_BIT-1)/2, integer division.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  reset; asynchronous assert, active-low.
- rx  input  1  UART line, asynchronous to clk.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled as 0.
- overrun  output  1  sticky; a completed byte was dropped because the holding register was full.
- ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n=0, async):
  - State=IDLE; both synchroniser flops=1; counters=0; shift register=0.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame and raises no error.
- Synchroniser: two flops; rs denotes the second flop. All decisions use rs only.
- 16-bit clk_count, 3-bit bit_index.
- States:
  - IDLE: clk_count=0, bit_index=0. If rs=0, go to START.
  - START: count 0..HALF. At clk_count==HALF: if rs=1 (glitch), go to IDLE with no output; else clk_count←0 and go to DATA.
  - DATA: at clk_count==CLKS_PER_BIT-1, shift rs into bit[bit_index] (LSB first) and set clk_count←0. After bit 7, bit_index←0 and go to STOP.
  - STOP: at clk_count==CLKS_PER_BIT-1, sample rs.
    - rs=1: deliver the byte, go to IDLE.
    - rs=0: pulse frame_err for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for rs=1, then go to IDLE. A held-low line (break) yields exactly one frame_err.
  - Unused encodings go to IDLE.
- Timing: if START is entered at cycle S:
  - start-bit check at S+HALF;
  - data bit n sampled at S+HALF+(n+1)*CLKS_PER_BIT;
  - stop bit sampled at S+HALF+9*CLKS_PER_BIT;
  - rx_valid/frame_err go high on the next cycle.
  - START is entered 3 clk edges after rx is first low at a clk edge (2 synchroniser + 1 state).
  - Default parameters: pin fall to rx_valid = 2065 cycles, ±1 for async phase.
- Delivery, on the cycle after the stop-bit sample:
  - If rx_valid=0, or rx_valid&rx_ready in that same cycle: load rx_data, rx_valid=1.
  - Otherwise keep the old rx_data and rx_valid=1, set overrun=1, and drop the new byte.
- Handshake:
  - rx_valid clears the cycle after rx_valid&rx_ready unless a delivery occurs in that same cycle.
  - rx_data never changes while rx_valid=1 except on a simultaneous accept+delivery.
- overrun:
  - ovr_clr=1 clears overrun.
  - Simultaneous ovr_clr and a new overrun event: overrun=1 (the set wins).
- The receiver returns to IDLE after the stop-bit sample and does not wait for the full stop-bit period. This tolerates up to about 4.5% combined baud mismatch; it also accepts back-to-back frames.
- Receive is never stalled by rx_ready; the frame state machine is independent of the handshake.

Test Plan:
- Reset, rx_ready=1, send 0xA5 at exactly 217 clk/bit → rx_valid pulses 1 cycle with rx_data=0xA5; frame_err=0, overrun=0; latency 2065±1 cycles from start edge.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap, rx_ready=1 → three deliveries in order; no errors.
- 50-cycle low glitch on idle line → returns to IDLE; no rx_valid, no frame_err. Then a valid 0x3C → received correctly.
- Frame 0x81 with stop bit 0 → one frame_err pulse, no rx_valid. Then line held low for 3 frame times → no further frame_err. Line high, then send 0x42 → rx_valid with 0x42.
- rx_ready=0, send 0x11 then 0x22 → rx_valid=1, rx_data=0x11, overrun=1. Set rx_ready=1 for 1 cycle → rx_valid=0. Pulse ovr_clr → overrun=0. Repeat at 208 and 226 clk/bit (±4%) → correct data.
- Assert rst_n=0 during data bit 4 of 0xC3, release, send 0x7E → all outputs 0 immediately on reset; no error; next byte 0x7E received.
